// File: rtl/data_mem_responder.sv
// Handshaked data-memory slave: accepts one load/store at a time, waits WAIT_STATES
// cycles, then presents read data or a store acknowledgement with an error flag.
module data_mem_responder #(
   parameter int DEPTH       = 1024,
   parameter int WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t      state_reg;
   logic [3:0]  cnt_reg;
   logic        write_reg;
   logic [15:0] addr_reg;
   logic [15:0] wdata_reg;
   logic        req_ready_reg;
   logic        rsp_valid_reg;
   logic        rsp_err_reg;
   logic [15:0] rsp_rdata_reg;

   // Storage survives reset; only the power-up image is preset.
   logic [15:0] mem [DEPTH] = '{0: 16'd5, 1: 16'd7, default: 16'd0};

   logic          accept;
   logic          fire;
   logic          cur_write;
   logic          cur_err;
   logic          mem_we;
   logic [15:0]   cur_addr;
   logic [15:0]   cur_wdata;
   logic [AW-1:0] mem_idx;

   // With zero wait states the response is produced on the accept edge itself,
   // so the request fields come straight from the ports instead of the latches.
   always_comb begin
      accept    = (state_reg == S_IDLE) && req_valid && req_ready_reg;
      fire      = (accept && (WAIT_STATES == 0)) ||
                  ((state_reg == S_WAIT) && (cnt_reg == 4'd0));
      cur_write = (state_reg == S_IDLE) ? req_write : write_reg;
      cur_addr  = (state_reg == S_IDLE) ? req_addr  : addr_reg;
      cur_wdata = (state_reg == S_IDLE) ? req_wdata : wdata_reg;
      cur_err   = cur_addr[0] | (32'(cur_addr[15:1]) >= 32'(DEPTH));
      mem_idx   = cur_addr[AW:1];
      mem_we    = fire && cur_write && !cur_err;
   end

   always_ff @(posedge clock) begin
      if (mem_we) begin
         mem[mem_idx] <= cur_wdata;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= S_IDLE;
         cnt_reg       <= 4'd0;
         write_reg     <= 1'b0;
         addr_reg      <= 16'd0;
         wdata_reg     <= 16'd0;
         req_ready_reg <= 1'b0;
         rsp_valid_reg <= 1'b0;
         rsp_err_reg   <= 1'b0;
         rsp_rdata_reg <= 16'd0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               req_ready_reg <= 1'b1;
               if (accept) begin
                  write_reg     <= req_write;
                  addr_reg      <= req_addr;
                  wdata_reg     <= req_wdata;
                  req_ready_reg <= 1'b0;
                  cnt_reg       <= WAIT_LOAD;
                  state_reg     <= (WAIT_STATES > 0) ? S_WAIT : S_RESP;
               end
            end
            S_WAIT: begin
               if (cnt_reg != 4'd0) begin
                  cnt_reg <= cnt_reg - 4'd1;
               end else begin
                  state_reg <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_reg     <= S_IDLE;
                  req_ready_reg <= 1'b1;
                  rsp_valid_reg <= 1'b0;
                  rsp_err_reg   <= 1'b0;
                  rsp_rdata_reg <= 16'd0;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase

         if (fire) begin
            rsp_valid_reg <= 1'b1;
            rsp_err_reg   <= cur_err;
            rsp_rdata_reg <= (cur_err || cur_write) ? 16'd0 : mem[mem_idx];
         end
      end
   end

   assign req_ready = req_ready_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one instance with 2 wait states, one with 0,
// expected responses queued at accept time and compared when the response appears.
module tb_data_mem_responder;
   logic        clock = 1'b0;
   logic        reset_n = 1'b0;

   logic        req_valid = 1'b0;
   logic        req_write = 1'b0;
   logic [15:0] req_addr = 16'd0;
   logic [15:0] req_wdata = 16'd0;
   logic        rsp_ready = 1'b1;
   logic        req_ready;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        rsp_err;

   logic        b_req_valid = 1'b0;
   logic        b_req_write = 1'b0;
   logic [15:0] b_req_addr = 16'd0;
   logic [15:0] b_req_wdata = 16'd0;
   logic        b_rsp_ready = 1'b1;
   logic        b_req_ready;
   logic        b_rsp_valid;
   logic [15:0] b_rsp_rdata;
   logic        b_rsp_err;

   int checks = 0;
   int failures = 0;
   logic [16:0] sb_q[$];   // {err, rdata}

   data_mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut_b (
      .clock(clock), .reset_n(reset_n),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
      .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [16:0] sb_pop(input string tag);
      logic [16:0] e;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $error("FAIL %s_scoreboard observed=empty expected=entry", tag);
         e = 17'd0;
      end else begin
         e = sb_q.pop_front();
      end
      return e;
   endfunction

   // Called just after the accept edge; returns on a negedge after the handshake.
   task automatic wait_rsp(input string tag);
      int lat;
      logic [16:0] e;
      lat = 0;
      @(negedge clock);
      check({tag, "_busy"}, 32'(req_ready), 32'd0);
      while (!rsp_valid && lat < 20) begin
         @(negedge clock);
         lat++;
      end
      check({tag, "_latency"}, 32'(lat), 32'd2);
      e = sb_pop(tag);
      check({tag, "_rdata"}, 32'(rsp_rdata), 32'(e[15:0]));
      check({tag, "_err"}, 32'(rsp_err), 32'(e[16]));
      $display("txn %s rdata=%h err=%0b latency=%0d", tag, rsp_rdata, rsp_err, lat);
      @(negedge clock);
      check({tag, "_rsp_clear"}, {15'd0, rsp_valid, rsp_rdata}, 32'd0);
      check({tag, "_ready_back"}, 32'(req_ready), 32'd1);
   endtask

   // Called on a negedge; req_* are scrambled after accept to show they are ignored.
   task automatic txn(input string tag, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wd, input logic [15:0] exp_rd, input logic exp_err);
      int waitc;
      req_valid = 1'b1;
      req_write = wr;
      req_addr  = addr;
      req_wdata = wd;
      waitc = 0;
      while (!req_ready && waitc < 20) begin
         @(negedge clock);
         waitc++;
      end
      check({tag, "_accept"}, 32'(req_ready), 32'd1);
      if (!req_ready) begin
         req_valid = 1'b0;
         return;
      end
      sb_q.push_back({exp_err, exp_rd});
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      req_write = 1'bx;
      req_addr  = 16'hxxxx;
      req_wdata = 16'hxxxx;
      wait_rsp(tag);
   endtask

   initial begin
      logic [16:0] e;
      // Reset state
      repeat (3) @(negedge clock);
      check("reset_req_ready", 32'(req_ready), 32'd0);
      check("reset_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
      check("reset_err", 32'(rsp_err), 32'd0);
      reset_n = 1'b1;
      #1;
      check("ready_before_edge", 32'(req_ready), 32'd0);
      @(negedge clock);
      check("ready_after_edge", 32'(req_ready), 32'd1);

      // Basic load, store/load-back, error cases and last word
      txn("load0", 1'b0, 16'd0, 16'd0, 16'd5, 1'b0);
      txn("store4", 1'b1, 16'd4, 16'h1234, 16'd0, 1'b0);
      txn("load4", 1'b0, 16'd4, 16'd0, 16'h1234, 1'b0);
      txn("load_odd3", 1'b0, 16'd3, 16'd0, 16'd0, 1'b1);
      txn("store_oor", 1'b1, 16'd2048, 16'hBEEF, 16'd0, 1'b1);
      txn("store_odd1", 1'b1, 16'd1, 16'hDEAD, 16'd0, 1'b1);
      txn("load2", 1'b0, 16'd2, 16'd0, 16'd7, 1'b0);
      txn("load0_again", 1'b0, 16'd0, 16'd0, 16'd5, 1'b0);
      txn("store_last", 1'b1, 16'd2046, 16'h5A5A, 16'd0, 1'b0);
      txn("load_last", 1'b0, 16'd2046, 16'd0, 16'h5A5A, 1'b0);
      txn("load_oor_top", 1'b0, 16'hFFFE, 16'd0, 16'd0, 1'b1);

      // Response backpressure with a new request held pending
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 16'd2;
      check("bp_accept", 32'(req_ready), 32'd1);
      sb_q.push_back({1'b0, 16'd7});
      @(posedge clock);
      #1;
      req_addr = 16'd4;
      begin
         int lat;
         lat = 0;
         @(negedge clock);
         while (!rsp_valid && lat < 20) begin
            @(negedge clock);
            lat++;
         end
         check("bp_latency", 32'(lat), 32'd2);
      end
      e = sb_pop("bp");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(rsp_valid), 32'd1);
         check("bp_hold_rdata", 32'(rsp_rdata), 32'(e[15:0]));
         check("bp_hold_err", 32'(rsp_err), 32'(e[16]));
         check("bp_hold_ready", 32'(req_ready), 32'd0);
         @(negedge clock);
      end
      $display("txn bp_load2 rdata=%h err=%0b held=5", rsp_rdata, rsp_err);
      rsp_ready = 1'b1;
      @(negedge clock);
      check("bp_released", 32'(rsp_valid), 32'd0);
      check("bp_ready_again", 32'(req_ready), 32'd1);
      sb_q.push_back({1'b0, 16'h1234});
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      check("bp_next_accepted", 32'(req_ready), 32'd0);
      wait_rsp("bp_next_load4");

      // Reset while a store is waiting: the store must be dropped
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 16'd2;
      req_wdata = 16'hAAAA;
      check("rst_store_accept", 32'(req_ready), 32'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("midrst_ready", 32'(req_ready), 32'd0);
      check("midrst_rsp", {15'd0, rsp_valid, rsp_rdata}, 32'd0);
      check("midrst_err", 32'(rsp_err), 32'd0);
      $display("txn midreset_store2 dropped");
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      check("postrst_ready", 32'(req_ready), 32'd1);
      txn("load2_after_rst", 1'b0, 16'd2, 16'd0, 16'd7, 1'b0);

      // Zero wait states: back-to-back loads
      b_req_valid = 1'b1;
      b_req_write = 1'b0;
      b_req_addr  = 16'd0;
      check("b_ready", 32'(b_req_ready), 32'd1);
      sb_q.push_back({1'b0, 16'd5});
      @(posedge clock);
      #1;
      b_req_addr = 16'd2;
      @(negedge clock);
      check("b_first_valid", 32'(b_rsp_valid), 32'd1);
      e = sb_pop("b_first");
      check("b_first_rdata", 32'(b_rsp_rdata), 32'(e[15:0]));
      check("b_first_err", 32'(b_rsp_err), 32'(e[16]));
      check("b_first_busy", 32'(b_req_ready), 32'd0);
      $display("txn b_load0 rdata=%h err=%0b", b_rsp_rdata, b_rsp_err);
      @(negedge clock);
      check("b_gap_valid", 32'(b_rsp_valid), 32'd0);
      check("b_gap_ready", 32'(b_req_ready), 32'd1);
      sb_q.push_back({1'b0, 16'd7});
      @(posedge clock);
      #1;
      b_req_valid = 1'b0;
      check("b_second_accept", 32'(b_rsp_valid), 32'd1);
      @(negedge clock);
      e = sb_pop("b_second");
      check("b_second_rdata", 32'(b_rsp_rdata), 32'(e[15:0]));
      check("b_second_err", 32'(b_rsp_err), 32'(e[16]));
      $display("txn b_load2 rdata=%h err=%0b", b_rsp_rdata, b_rsp_err);
      @(negedge clock);
      check("b_done_valid", 32'(b_rsp_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
